// File: rtl/dmem_lsu.sv
// Data memory with a valid/ready load/store port, wait-state latency and an always-ready fetch port.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned/illegal accesses instead of force-aligning them.
module dmem_lsu #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_unsigned,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_data
);

    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_d;
    logic               accept;
    logic               exec_fire;

    logic               h_we, h_uns;
    logic [1:0]         h_size;
    logic [ADDR_W-1:0]  h_addr;
    logic [31:0]        h_wdata;

    logic               op_we, op_uns;
    logic [1:0]         op_size, eff_size;
    logic [ADDR_W-1:0]  op_addr, eff_addr;
    logic [31:0]        op_wdata;

    logic               err_c;
    logic [3:0]         be;
    logic [31:0]        wlane, rd_word, shifted, ld_data;

    logic [31:0]        mem [DEPTH] = '{default: '0};

    // State, wait counter and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= ready_d;
            rsp_valid <= (state_d == S_RESP);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b1;
        exec_fire = 1'b0;
        accept    = req_valid && req_ready;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d   = S_RESP;
                        exec_fire = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_RESP;
                    exec_fire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d != S_WAIT);
    end

    // Request capture so the requester may move on after acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_we    <= 1'b0;
            h_uns   <= 1'b0;
            h_size  <= '0;
            h_addr  <= '0;
            h_wdata <= '0;
        end else if (accept) begin
            h_we    <= req_we;
            h_uns   <= req_unsigned;
            h_size  <= req_size;
            h_addr  <= req_addr;
            h_wdata <= req_wdata;
        end
    end

    // Single-cycle latency executes on the accepting edge, so use live fields there
    assign op_we    = (LATENCY == 1) ? req_we       : h_we;
    assign op_uns   = (LATENCY == 1) ? req_unsigned : h_uns;
    assign op_size  = (LATENCY == 1) ? req_size     : h_size;
    assign op_addr  = (LATENCY == 1) ? req_addr     : h_addr;
    assign op_wdata = (LATENCY == 1) ? req_wdata    : h_wdata;

    always_comb begin
        eff_size = op_size;
        eff_addr = op_addr;
        err_c    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        case (op_size)
            2'b01:   err_c = op_addr[0];
            2'b10:   err_c = |op_addr[1:0];
            2'b11:   err_c = 1'b1;
            default: err_c = 1'b0;
        endcase
`else
        if (op_size == 2'b11) eff_size = 2'b10;
        if (eff_size == 2'b01) eff_addr[0] = 1'b0;
        if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        rd_word = mem[eff_addr[ADDR_W-1:2]];
        shifted = rd_word >> {eff_addr[1:0], 3'b000};
        case (eff_size)
            2'b00: begin
                be      = 4'b0001 << eff_addr[1:0];
                wlane   = {4{op_wdata[7:0]}};
                ld_data = op_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be      = eff_addr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{op_wdata[15:0]}};
                ld_data = op_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be      = 4'b1111;
                wlane   = op_wdata;
                ld_data = rd_word;
            end
        endcase
    end

    // Byte-lane writes; reset aborts any execution on the same edge
    always_ff @(posedge clk) begin
        if (exec_fire && op_we && !err_c && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[eff_addr[ADDR_W-1:2]][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            i_data    <= '0;
        end else begin
            rsp_rdata <= (exec_fire && !op_we && !err_c) ? ld_data : 32'd0;
            rsp_err   <= exec_fire && err_c;
            i_data    <= mem[WORD_W'(i_addr >> 2)];
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a LATENCY=1 instance and a LATENCY=4 instance.
module tb_dmem_lsu;

    localparam int unsigned AW = 14;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          a_valid, a_ready, a_we, a_uns, a_rvalid, a_err;
    logic [1:0]    a_size;
    logic [AW-1:0] a_addr, a_iaddr;
    logic [31:0]   a_wdata, a_rdata, a_idata;

    logic          b_valid, b_ready, b_we, b_uns, b_rvalid, b_err;
    logic [1:0]    b_size;
    logic [AW-1:0] b_addr, b_iaddr;
    logic [31:0]   b_wdata, b_rdata, b_idata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_lsu #(.ADDR_W(AW), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_unsigned(a_uns),
        .req_size(a_size), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_err(a_err),
        .i_addr(a_iaddr), .i_data(a_idata)
    );

    dmem_lsu #(.ADDR_W(AW), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_unsigned(b_uns),
        .req_size(b_size), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err),
        .i_addr(b_iaddr), .i_data(b_idata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present on the LATENCY=1 port at a negedge; response is visible one negedge later
    task automatic a_xfer(input logic we, input logic uns, input logic [1:0] size,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        a_valid = 1'b1; a_we = we; a_uns = uns; a_size = size; a_addr = addr; a_wdata = wdata;
        @(negedge clk);
        check({tag, " vld"},   32'(a_rvalid), 32'd1);
        check({tag, " rdy"},   32'(a_ready),  32'd1);
        check({tag, " rdata"}, a_rdata,       exp_rdata);
        check({tag, " err"},   32'(a_err),    32'(exp_err));
    endtask

    // One full LATENCY=4 transaction from acceptance (cycle 0) through cycle 5
    task automatic b_xfer(input logic we, input logic uns, input logic [1:0] size,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input string tag);
        b_valid = 1'b1; b_we = we; b_uns = uns; b_size = size; b_addr = addr; b_wdata = wdata;
        @(negedge clk);
        b_valid = 1'b0; b_wdata = 32'hFFFF_FFFF; b_addr = '0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("%s rdy c%0d", tag, c), 32'(b_ready),  32'd0);
            check($sformatf("%s vld c%0d", tag, c), 32'(b_rvalid), 32'd0);
            @(negedge clk);
        end
        check({tag, " vld c4"}, 32'(b_rvalid), 32'd1);
        check({tag, " rdy c4"}, 32'(b_ready),  32'd1);
        check({tag, " rdata"},  b_rdata,       exp_rdata);
        check({tag, " err"},    32'(b_err),    32'd0);
        @(negedge clk);
        check({tag, " vld c5"}, 32'(b_rvalid), 32'd0);
    endtask

    initial begin
        logic seen;
        a_valid = 0; a_we = 0; a_uns = 0; a_size = 0; a_addr = '0; a_wdata = '0; a_iaddr = '0;
        b_valid = 0; b_we = 0; b_uns = 0; b_size = 0; b_addr = '0; b_wdata = '0; b_iaddr = '0;

        #2 reset = 1'b1;
        #1;
        check("rst a_rdy",   32'(a_ready),  32'd1);
        check("rst a_vld",   32'(a_rvalid), 32'd0);
        check("rst a_rdata", a_rdata,       32'd0);
        check("rst a_err",   32'(a_err),    32'd0);
        check("rst a_idata", a_idata,       32'd0);
        check("rst b_rdy",   32'(b_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back accesses on the single-cycle port
        a_xfer(1, 0, 2'b10, 14'h10, 32'hDEAD_BEEF, 32'h0,          1'b0, "sw");
        a_xfer(0, 0, 2'b10, 14'h10, 32'h0,         32'hDEAD_BEEF,  1'b0, "lw");
        a_xfer(1, 0, 2'b00, 14'h13, 32'h0000_0080, 32'h0,          1'b0, "sb");
        a_xfer(0, 0, 2'b00, 14'h13, 32'h0,         32'hFFFF_FF80,  1'b0, "lb");
        a_xfer(0, 1, 2'b00, 14'h13, 32'h0,         32'h0000_0080,  1'b0, "lbu");
        a_xfer(0, 0, 2'b10, 14'h10, 32'h0,         32'h80AD_BEEF,  1'b0, "lw2");
        a_xfer(0, 0, 2'b01, 14'h12, 32'h0,         32'hFFFF_80AD,  1'b0, "lh");
        a_xfer(0, 1, 2'b01, 14'h12, 32'h0,         32'h0000_80AD,  1'b0, "lhu");
        a_xfer(0, 1, 2'b10, 14'h10, 32'h0,         32'h80AD_BEEF,  1'b0, "lw_uns");

        // Misaligned / illegal handling
        a_xfer(1, 0, 2'b10, 14'h22, 32'h1234_5678, 32'h0, TRAP, "sw_mis");
        a_xfer(0, 0, 2'b10, 14'h20, 32'h0, TRAP ? 32'h0 : 32'h1234_5678, 1'b0, "lw_after");
        a_xfer(0, 0, 2'b01, 14'h21, 32'h0, TRAP ? 32'h0 : 32'h0000_5678, TRAP, "lh_mis");
        a_xfer(0, 0, 2'b11, 14'h20, 32'h0, TRAP ? 32'h0 : 32'h1234_5678, TRAP, "sz11");
        a_valid = 1'b0;
        @(negedge clk);
        check("idle vld", 32'(a_rvalid), 32'd0);
        check("idle rdy", 32'(a_ready),  32'd1);

        // Fetch racing a store to the same word
        a_iaddr = 14'h10;
        a_xfer(1, 0, 2'b10, 14'h10, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_f");
        check("fetch old", a_idata, 32'h80AD_BEEF);
        a_valid = 1'b0;
        @(negedge clk);
        check("fetch new", a_idata, 32'hCAFE_F00D);

        // Wait-state port
        b_xfer(1, 0, 2'b10, 14'h20, 32'h1122_3344, 32'h0,         "l4_sw");
        b_xfer(0, 0, 2'b01, 14'h20, 32'h0,         32'h0000_3344, "l4_lh");
        b_xfer(0, 0, 2'b00, 14'h23, 32'h0,         32'h0000_0011, "l4_lb");
        b_xfer(0, 1, 2'b01, 14'h22, 32'h0,         32'h0000_1122, "l4_lhu");

        // Reset during cycle 2 of a pending store
        b_valid = 1'b1; b_we = 1'b1; b_uns = 1'b0; b_size = 2'b10; b_addr = 14'h20; b_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        b_valid = 1'b0;
        check("mid rdy c1", 32'(b_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid rst rdy",   32'(b_ready),  32'd1);
        check("mid rst vld",   32'(b_rvalid), 32'd0);
        check("mid rst idata", a_idata,       32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | b_rvalid;
        end
        check("mid no rsp", 32'(seen), 32'd0);
        b_xfer(0, 0, 2'b10, 14'h20, 32'h0, 32'h1122_3344, "l4_keep");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
